// File: rtl/spi_flash_read_seq_if.sv
// Bus bundle for spi_flash_read_seq: read-request channel, read-data stream
// and the APB master port towards the SPI master peripheral.
// master = the sequencer side, slave = the surrounding system.
`timescale 1ns/1ps
interface spi_flash_read_seq_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_W          = 10
);
    logic                      req_valid;
    logic                      req_ready;
    logic [23:0]               req_addr;
    logic [CNT_W-1:0]          req_words;
    logic                      req_quad;
    logic [1:0]                req_cs;
    logic [31:0]               rd_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic                      done;
    logic                      err;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_addr, req_words, req_quad, req_cs, rd_ready,
               PRDATA, PREADY, PSLVERR,
        output req_ready, rd_data, rd_valid, done, err,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid, req_addr, req_words, req_quad, req_cs, rd_ready,
               PRDATA, PREADY, PSLVERR,
        input  req_ready, rd_data, rd_valid, done, err,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq: APB master that programs the SPI master for one flash
// read (single 0x03 or quad 0xEB), drains its RX FIFO into a valid/ready
// stream and pulses done. Every APB access starts with a PSEL-low gap cycle,
// then SETUP, then ACCESS held until PREADY.
// Optional build macro SPI_SEQ_TIMEOUT_EN adds a polling watchdog.
`timescale 1ns/1ps
module spi_flash_read_seq #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_W          = 10,
    parameter int DUMMY_QRD      = 8,
    parameter int TO_CYCLES      = 65535
) (
    input logic                  HCLK,
    input logic                  HRESET,
    spi_flash_read_seq_if.master bus
);
    localparam logic [5:0] OFS_STATUS = 6'h00;
    localparam logic [5:0] OFS_CMD    = 6'h08;
    localparam logic [5:0] OFS_ADR    = 6'h0C;
    localparam logic [5:0] OFS_LEN    = 6'h10;
    localparam logic [5:0] OFS_DUM    = 6'h14;
    localparam logic [5:0] OFS_RXF    = 6'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_W_LEN, S_W_CMD, S_W_ADR, S_W_DUM, S_W_GO, S_POLL_RX,
        S_R_FIFO, S_PUSH, S_POLL_EOT, S_ERR_RST, S_DONE
    } state_t;

    function automatic logic [3:0] f_cs_onehot(input logic [1:0] cs);
        logic [3:0] oh;
        case (cs)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t                    r_state, w_state_nx;
    logic                      r_psel, w_psel_nx, r_penable, w_penable_nx;
    logic                      r_pwrite, w_pwrite_nx;
    logic [APB_ADDR_WIDTH-1:0] r_paddr, w_paddr_nx;
    logic [31:0]               r_pwdata, w_pwdata_nx;
    logic [23:0]               r_addr, w_addr_nx;
    logic [CNT_W-1:0]          r_words, w_words_nx, r_remain, w_remain_nx;
    logic                      r_quad, w_quad_nx;
    logic [1:0]                r_cs, w_cs_nx;
    logic [31:0]               r_rd_data, w_rd_data_nx;
    logic                      r_rd_valid, w_rd_valid_nx, r_done, w_done_nx;
    logic                      r_err, w_err_nx, r_req_ready, w_req_ready_nx;

    logic [5:0]                w_acc_off;
    logic                      w_acc_wr;
    logic [31:0]               w_acc_wdata;
    logic [15:0]               w_len_data;
    logic                      w_polling;
    logic                      w_timeout;

    // Data length in bits; wider counts simply wrap in the 16-bit field.
    assign w_len_data = 16'({r_words, 5'b00000});
    assign w_polling  = (r_state == S_POLL_RX) || (r_state == S_POLL_EOT);

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] r_wdog, w_wdog_nx;

    // Count cycles stuck in a poll state; any exit (FIFO pop, idle seen) restarts it.
    always_comb begin
        w_wdog_nx = 16'h0000;
        if (w_polling && (r_wdog != 16'hFFFF)) begin
            w_wdog_nx = r_wdog + 16'h0001;
        end else if (w_polling) begin
            w_wdog_nx = r_wdog;
        end else begin
            w_wdog_nx = 16'h0000;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_wdog <= 16'h0000;
        end else begin
            r_wdog <= w_wdog_nx;
        end
    end

    assign w_timeout = w_polling && (r_wdog >= 16'(TO_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // Decode which SPI master register the current state touches and with what.
    always_comb begin
        w_acc_off   = OFS_STATUS;
        w_acc_wr    = 1'b0;
        w_acc_wdata = 32'h0000_0000;
        case (r_state)
            S_W_LEN:   begin w_acc_off = OFS_LEN; w_acc_wr = 1'b1;
                             w_acc_wdata = {w_len_data, 2'b00, 6'd24, 2'b00, 6'd8}; end
            S_W_CMD:   begin w_acc_off = OFS_CMD; w_acc_wr = 1'b1;
                             w_acc_wdata = {(r_quad ? 8'hEB : 8'h03), 24'h00_0000}; end
            S_W_ADR:   begin w_acc_off = OFS_ADR; w_acc_wr = 1'b1;
                             w_acc_wdata = {r_addr, 8'h00}; end
            S_W_DUM:   begin w_acc_off = OFS_DUM; w_acc_wr = 1'b1;
                             w_acc_wdata = r_quad ? 32'(DUMMY_QRD) : 32'h0000_0000; end
            S_W_GO:    begin w_acc_off = OFS_STATUS; w_acc_wr = 1'b1;
                             w_acc_wdata = {20'h0_0000, f_cs_onehot(r_cs), 5'b00000,
                                            r_quad, 1'b0, ~r_quad}; end
            S_R_FIFO:  begin w_acc_off = OFS_RXF; end
            S_ERR_RST: begin w_acc_off = OFS_STATUS; w_acc_wr = 1'b1;
                             w_acc_wdata = 32'h0000_0010; end
            default:   begin w_acc_off = OFS_STATUS; end
        endcase
    end

    // Next-state and next-output logic for the sequencer and its APB phases.
    always_comb begin
        w_state_nx     = r_state;
        w_psel_nx      = r_psel;
        w_penable_nx   = r_penable;
        w_pwrite_nx    = r_pwrite;
        w_paddr_nx     = r_paddr;
        w_pwdata_nx    = r_pwdata;
        w_addr_nx      = r_addr;
        w_words_nx     = r_words;
        w_remain_nx    = r_remain;
        w_quad_nx      = r_quad;
        w_cs_nx        = r_cs;
        w_rd_data_nx   = r_rd_data;
        w_rd_valid_nx  = r_rd_valid;
        w_done_nx      = 1'b0;
        w_err_nx       = r_err;
        w_req_ready_nx = r_req_ready;
        case (r_state)
            S_IDLE: begin
                w_req_ready_nx = 1'b1;
                if (bus.req_valid && r_req_ready) begin
                    w_addr_nx      = bus.req_addr;
                    w_words_nx     = bus.req_words;
                    w_remain_nx    = bus.req_words;
                    w_quad_nx      = bus.req_quad;
                    w_cs_nx        = bus.req_cs;
                    w_err_nx       = 1'b0;
                    w_req_ready_nx = 1'b0;
                    w_state_nx     = S_W_LEN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_PUSH: begin
                if (bus.rd_ready) begin
                    w_rd_valid_nx = 1'b0;
                    w_remain_nx   = r_remain - {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nx    = (r_remain == {{(CNT_W-1){1'b0}}, 1'b1}) ? S_POLL_EOT : S_POLL_RX;
                end else begin
                    w_state_nx = S_PUSH;
                end
            end
            S_DONE: begin
                w_req_ready_nx = 1'b1;
                w_state_nx     = S_IDLE;
            end
            default: begin
                // Every remaining state runs exactly one APB access.
                if (!r_psel) begin
                    if (w_timeout) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_ERR_RST;
                    end else begin
                        w_psel_nx    = 1'b1;
                        w_penable_nx = 1'b0;
                        w_pwrite_nx  = w_acc_wr;
                        w_paddr_nx   = APB_ADDR_WIDTH'(w_acc_off);
                        w_pwdata_nx  = w_acc_wdata;
                    end
                end else if (!r_penable) begin
                    w_penable_nx = 1'b1;
                end else if (bus.PREADY) begin
                    w_psel_nx    = 1'b0;
                    w_penable_nx = 1'b0;
                    w_pwrite_nx  = 1'b0;
                    if (bus.PSLVERR && (r_state != S_ERR_RST)) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = S_ERR_RST;
                    end else begin
                        case (r_state)
                            S_W_LEN:    w_state_nx = S_W_CMD;
                            S_W_CMD:    w_state_nx = S_W_ADR;
                            S_W_ADR:    w_state_nx = S_W_DUM;
                            S_W_DUM:    w_state_nx = S_W_GO;
                            S_W_GO:     w_state_nx = (r_remain == {CNT_W{1'b0}}) ? S_POLL_EOT : S_POLL_RX;
                            S_POLL_RX:  w_state_nx = (bus.PRDATA[23:16] != 8'h00) ? S_R_FIFO : S_POLL_RX;
                            S_R_FIFO: begin
                                w_rd_data_nx  = bus.PRDATA;
                                w_rd_valid_nx = 1'b1;
                                w_state_nx    = S_PUSH;
                            end
                            S_POLL_EOT: begin
                                w_done_nx  = bus.PRDATA[0];
                                w_state_nx = bus.PRDATA[0] ? S_DONE : S_POLL_EOT;
                            end
                            S_ERR_RST: begin
                                w_done_nx  = 1'b1;
                                w_state_nx = S_DONE;
                            end
                            default:    w_state_nx = S_IDLE;
                        endcase
                    end
                end else begin
                    w_psel_nx = r_psel;
                end
            end
        endcase
    end

    // State register plus all registered outputs; reset abandons any transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= {APB_ADDR_WIDTH{1'b0}};
            r_pwdata    <= 32'h0000_0000;
            r_addr      <= 24'h00_0000;
            r_words     <= {CNT_W{1'b0}};
            r_remain    <= {CNT_W{1'b0}};
            r_quad      <= 1'b0;
            r_cs        <= 2'd0;
            r_rd_data   <= 32'h0000_0000;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_psel      <= w_psel_nx;
            r_penable   <= w_penable_nx;
            r_pwrite    <= w_pwrite_nx;
            r_paddr     <= w_paddr_nx;
            r_pwdata    <= w_pwdata_nx;
            r_addr      <= w_addr_nx;
            r_words     <= w_words_nx;
            r_remain    <= w_remain_nx;
            r_quad      <= w_quad_nx;
            r_cs        <= w_cs_nx;
            r_rd_data   <= w_rd_data_nx;
            r_rd_valid  <= w_rd_valid_nx;
            r_done      <= w_done_nx;
            r_err       <= w_err_nx;
            r_req_ready <= w_req_ready_nx;
        end
    end

    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.req_ready = r_req_ready;
endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: an abstract SPI-master/flash model answers
// APB accesses; expected APB writes, read words and done results are queued
// when each request is issued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    spi_flash_read_seq_if #(.APB_ADDR_WIDTH(12), .CNT_W(10)) bus ();
    spi_flash_read_seq #(.APB_ADDR_WIDTH(12), .CNT_W(10), .DUMMY_QRD(8), .TO_CYCLES(65535))
        dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    typedef struct { bit err; int nreads; } exp_done_t;
    logic [37:0] exp_wr[$];
    logic [31:0] exp_words[$];
    exp_done_t   exp_done[$];
    int checks = 0;
    int errors = 0;
    int rx_reads = 0;

    // flash / SPI master model state
    logic [31:0] fifo_q[$];
    logic [31:0] m_spilen, m_spiadr;
    logic [23:0] prod_addr;
    int to_produce, idle_cnt, wait_cnt;
    bit busy;
    bit inj_armed;
    logic [5:0] inj_addr;
    logic [5:0] off;
    int bp_hold = 0;
    bit bp_arm = 1'b0;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return ({a, 8'h00} ^ {8'h00, a}) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // APB slave side of the SPI master plus the flash data producer.
    initial begin
        bus.PREADY = 1'b0; bus.PRDATA = 32'h0; bus.PSLVERR = 1'b0;
        busy = 1'b0; to_produce = 0; idle_cnt = 0; wait_cnt = 0; inj_armed = 1'b0;
        m_spilen = 32'h0; m_spiadr = 32'h0; prod_addr = 24'h0; inj_addr = 6'h0;
        forever begin
            @(posedge HCLK); #1;
            bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h0;
            if (!HRESET) begin
                if (busy) begin
                    if (to_produce > 0) begin
                        if ($urandom_range(0, 2) == 0) begin
                            fifo_q.push_back(flash_word(prod_addr));
                            prod_addr = prod_addr + 24'd4;
                            to_produce--;
                        end
                    end else if (idle_cnt > 0) idle_cnt--;
                    else busy = 1'b0;
                end
                if (bus.PSEL && !bus.PENABLE) wait_cnt = $urandom_range(0, 2);
                else if (bus.PSEL && bus.PENABLE) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        bus.PREADY = 1'b1;
                        off = bus.PADDR[5:0];
                        if (inj_armed && bus.PWRITE && off == inj_addr) begin
                            bus.PSLVERR = 1'b1;
                            inj_armed = 1'b0;
                        end else if (bus.PWRITE) begin
                            if (off == 6'h10) m_spilen = bus.PWDATA;
                            else if (off == 6'h0C) m_spiadr = bus.PWDATA;
                            else if (off == 6'h00 && bus.PWDATA[4]) begin
                                fifo_q.delete(); busy = 1'b0; to_produce = 0;
                            end else if (off == 6'h00 && (bus.PWDATA[0] || bus.PWDATA[2])) begin
                                busy = 1'b1;
                                to_produce = int'(m_spilen[31:16]) / 32;
                                prod_addr = m_spiadr[31:8];
                                idle_cnt = $urandom_range(0, 4);
                            end
                        end else if (off == 6'h20) begin
                            bus.PRDATA = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hDEAD_0000;
                        end else begin
                            bus.PRDATA = {8'h00, 8'(fifo_q.size()), 15'h0000, ~busy};
                        end
                    end
                end
            end
        end
    end

    // Downstream consumer: random ready, with an optional 20-cycle stall.
    initial begin
        bus.rd_ready = 1'b0;
        forever begin
            @(posedge HCLK); #1;
            if (bp_arm && bus.rd_valid) begin bp_hold = 20; bp_arm = 1'b0; end
            if (bp_hold > 0) begin bus.rd_ready = 1'b0; bp_hold--; end
            else bus.rd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        logic p_psel, p_pen, p_pready, p_valid, p_ready, p_done;
        logic [31:0] p_data;
        logic [37:0] e;
        exp_done_t ed;
        p_psel = 0; p_pen = 0; p_pready = 0; p_valid = 0; p_ready = 0; p_done = 0; p_data = 0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                p_psel = 0; p_pen = 0; p_pready = 0; p_valid = 0; p_ready = 0; p_done = 0;
            end else begin
                if (bus.PENABLE) chk(bus.PSEL, "penable_without_psel", 64'(bus.PSEL), 64'd1);
                if (p_psel && !p_pen) chk(bus.PSEL && bus.PENABLE, "setup_to_access", 64'(bus.PENABLE), 64'd1);
                if (p_psel && p_pen && !p_pready) chk(bus.PSEL && bus.PENABLE, "access_hold", 64'(bus.PSEL), 64'd1);
                if (p_psel && p_pen && p_pready) chk(!bus.PSEL, "psel_gap", 64'(bus.PSEL), 64'd0);
                if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
                    if (bus.PWRITE) begin
                        if (exp_wr.size() == 0) chk(1'b0, "apb_wr_unexpected", 64'({bus.PADDR[5:0], bus.PWDATA}), 64'd0);
                        else begin
                            e = exp_wr.pop_front();
                            chk({bus.PADDR[5:0], bus.PWDATA} == e && bus.PADDR[11:6] == 6'h00, "apb_wr",
                                64'({bus.PADDR, bus.PWDATA}), 64'(e));
                        end
                    end else begin
                        chk(bus.PADDR == 12'h000 || bus.PADDR == 12'h020, "apb_rd_addr", 64'(bus.PADDR), 64'h20);
                        if (bus.PADDR == 12'h020) rx_reads++;
                    end
                end
                if (p_valid && !p_ready) begin
                    chk(bus.rd_valid, "rd_valid_hold", 64'(bus.rd_valid), 64'd1);
                    chk(bus.rd_data == p_data, "rd_data_stable", 64'(bus.rd_data), 64'(p_data));
                end
                if (bus.rd_valid) chk(!bus.PSEL, "apb_idle_in_push", 64'(bus.PSEL), 64'd0);
                if (bus.rd_valid && bus.rd_ready) begin
                    chk(!bus.err, "rd_valid_with_err", 64'(bus.err), 64'd0);
                    if (exp_words.size() == 0) chk(1'b0, "rd_unexpected", 64'(bus.rd_data), 64'd0);
                    else begin
                        p_data = exp_words.pop_front();
                        chk(bus.rd_data == p_data, "rd_data", 64'(bus.rd_data), 64'(p_data));
                    end
                end
                if (bus.done) begin
                    chk(!p_done, "done_single_pulse", 64'(p_done), 64'd0);
                    if (exp_done.size() == 0) chk(1'b0, "done_unexpected", 64'd1, 64'd0);
                    else begin
                        ed = exp_done.pop_front();
                        chk(bus.err == ed.err, "done_err", 64'(bus.err), 64'(ed.err));
                        chk(rx_reads == ed.nreads, "rxfifo_reads", 64'(rx_reads), 64'(ed.nreads));
                        chk(exp_words.size() == 0, "words_left", 64'(exp_words.size()), 64'd0);
                    end
                    rx_reads = 0;
                end
                p_psel = bus.PSEL; p_pen = bus.PENABLE; p_pready = bus.PREADY;
                p_valid = bus.rd_valid; p_ready = bus.rd_ready; p_done = bus.done;
                p_data = bus.rd_data;
            end
        end
    end

    task automatic issue_req(input logic [23:0] a, input int w, input bit q, input logic [1:0] cs,
                             input bit inj, input logic [5:0] inj_a);
        logic [31:0] wd[5];
        logic [5:0]  wa[5];
        exp_done_t   ed;
        bit hit;
        bit got;
        wa[0] = 6'h10; wa[1] = 6'h08; wa[2] = 6'h0C; wa[3] = 6'h14; wa[4] = 6'h00;
        wd[0] = (((32'(w) * 32'd32) & 32'h0000_FFFF) << 16) | (32'd24 << 8) | 32'd8;
        wd[1] = (q ? 32'hEB : 32'h03) << 24;
        wd[2] = 32'(a) << 8;
        wd[3] = q ? 32'd8 : 32'd0;
        wd[4] = (32'h100 << cs) | (q ? 32'h4 : 32'h1);
        hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!hit) begin
                exp_wr.push_back({wa[i], wd[i]});
                if (inj && wa[i] == inj_a) hit = 1'b1;
            end
        end
        if (hit) begin
            exp_wr.push_back({6'h00, 32'h0000_0010});
            ed.err = 1'b1; ed.nreads = 0;
        end else begin
            for (int i = 0; i < w; i++) exp_words.push_back(flash_word(a + 24'(4 * i)));
            ed.err = 1'b0; ed.nreads = w;
        end
        exp_done.push_back(ed);
        inj_armed = inj; inj_addr = inj_a;
        @(negedge HCLK);
        bus.req_addr = a; bus.req_words = 10'(w); bus.req_quad = q; bus.req_cs = cs;
        bus.req_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            if (bus.req_ready) got = 1'b1;
            else @(negedge HCLK);
        end
        if (!got) begin
            chk(1'b0, "req_accept_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge HCLK); #1;
            bus.req_valid = 1'b0;
            chk(!bus.req_ready, "req_ready_busy", 64'(bus.req_ready), 64'd0);
            chk(!bus.err, "err_cleared_on_accept", 64'(bus.err), 64'd0);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(negedge HCLK);
            if (bus.req_ready) ok = 1'b1;
        end
        chk(ok, "request_completion_timeout", 64'(ok), 64'd1);
    endtask

    task automatic do_req(input logic [23:0] a, input int w, input bit q, input logic [1:0] cs,
                          input bit inj, input logic [5:0] inj_a);
        issue_req(a, w, q, cs, inj, inj_a);
        wait_idle();
    endtask

    initial begin
        logic [5:0] offs[5];
        bus.req_valid = 1'b0; bus.req_addr = 24'h0; bus.req_words = 10'd0;
        bus.req_quad = 1'b0; bus.req_cs = 2'd0;
        offs[0] = 6'h10; offs[1] = 6'h08; offs[2] = 6'h0C; offs[3] = 6'h14; offs[4] = 6'h00;
        repeat (3) @(negedge HCLK);
        chk(bus.req_ready == 1'b1, "rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rd_valid, bus.done, bus.err} == 6'b0,
            "rst_outputs", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rd_valid, bus.done, bus.err}), 64'd0);
        chk(bus.PADDR == 12'h0 && bus.PWDATA == 32'h0 && bus.rd_data == 32'h0, "rst_buses",
            64'(bus.PWDATA), 64'd0);
        HRESET = 1'b0;

        do_req(24'h001000, 2, 1'b0, 2'd0, 1'b0, 6'h00);
        do_req(24'h3A5C10, 1, 1'b1, 2'd2, 1'b0, 6'h00);
        bp_arm = 1'b1;
        do_req(24'h00ABC0, 2, 1'b0, 2'd1, 1'b0, 6'h00);
        do_req(24'h123456, 0, 1'b0, 2'd3, 1'b0, 6'h00);
        do_req(24'h000800, 3, 1'b0, 2'd0, 1'b1, 6'h08);
        do_req(24'hFFFFF8, 3, 1'b1, 2'd1, 1'b0, 6'h00);

        for (int k = 0; k < 25; k++) begin
            bit inj;
            inj = ($urandom_range(0, 4) == 0);
            bp_arm = ($urandom_range(0, 5) == 0);
            do_req(24'($urandom), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), inj, offs[$urandom_range(0, 4)]);
        end

        // asynchronous reset in the middle of a request
        issue_req(24'h0F0F00, 3, 1'b1, 2'd0, 1'b0, 6'h00);
        repeat (8) @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        chk({bus.PSEL, bus.PENABLE, bus.PWRITE} == 3'b000 && bus.PADDR == 12'h0 && bus.PWDATA == 32'h0,
            "async_rst_apb", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'd0);
        chk(bus.req_ready && !bus.rd_valid && !bus.done, "async_rst_handshake",
            64'({bus.req_ready, bus.rd_valid, bus.done}), 64'h4);
        exp_wr.delete(); exp_words.delete(); exp_done.delete();
        fifo_q.delete(); busy = 1'b0; to_produce = 0; inj_armed = 1'b0; rx_reads = 0;
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        do_req(24'h0000C4, 2, 1'b0, 2'd2, 1'b0, 6'h00);

        repeat (5) @(negedge HCLK);
        chk(exp_wr.size() == 0, "wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        chk(exp_words.size() == 0, "word_queue_empty", 64'(exp_words.size()), 64'd0);
        chk(exp_done.size() == 0, "done_queue_empty", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
